fir_sym_tdm: RTL and testbench

FIR_SYM_TDM -- requirements
Module: fir_sym_tdm

---
 rtl/fir_sym_tdm.sv | 187 ++++++++++++++++++
 tb/tb_fir_sym_tdm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_tdm.sv
`timescale 1ns/1ps
// Symmetric folded FIR; CH channels share one pre-add/multiply/accumulate path.
// Build option FIR_SAT_EN clamps the output to OUT_W bits; without it the result wraps.
module fir_sym_tdm #(
    parameter int D_W   = 12,
    parameter int C_W   = 18,
    parameter int TAPS  = 49,
    parameter int CH    = 2,
    parameter int OUT_W = 24,
    parameter int SHIFT = 17,
    localparam int H     = (TAPS + 1) / 2,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW    = (H > 1) ? $clog2(H) : 1,
    localparam int ACC_W = D_W + 1 + C_W + $clog2(H)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [D_W-1:0]   in_data,
    input  logic [CW-1:0]           in_ch,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [CW-1:0]           out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    coeff_wr,
    input  logic [AW-1:0]           coeff_addr,
    input  logic signed [C_W-1:0]   coeff_data,
    output logic                    busy
);
    localparam int PW = D_W + 1 + C_W;
    localparam int RW = ACC_W + 1;
    localparam int KW = $clog2(H + 1);
    localparam logic signed [RW-1:0] RND_K =
        (SHIFT > 0) ? RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [CW-1:0]           ch_q, ch_d, out_ch_q, out_ch_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    prod_vld_q, prod_vld_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic signed [D_W-1:0]   dl_q [CH][TAPS];
    logic signed [D_W-1:0]   dl_d [CH][TAPS];
    logic signed [C_W-1:0]   coef_q [H];
    logic signed [C_W-1:0]   coef_d [H];
    logic signed [D_W-1:0]   x_sel [TAPS];
    logic signed [D_W:0]     pre;
    logic signed [C_W-1:0]   coef_sel;
    logic                    accept, coef_we;

    // Half-up rounding: add half an output LSB, then arithmetic shift.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] t;
        t = RW'(a);
        if (SHIFT > 0) t = t + RND_K;
        return t >>> SHIFT;
    endfunction

`ifdef FIR_SAT_EN
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = ~OMAX;
    function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [RW-1:0] r);
        if (r > OMAX) return OMAX[OUT_W-1:0];
        if (r < OMIN) return OMIN[OUT_W-1:0];
        return OUT_W'(r);
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [RW-1:0] r);
        return OUT_W'(r);
    endfunction
`endif

    always_comb begin
        x_sel = dl_q[0];
        for (int c = 1; c < CH; c++) if (ch_q == CW'(c)) x_sel = dl_q[c];
        pre      = '0;
        coef_sel = '0;
        // Fold mirrored taps; the centre tap is used once, not doubled.
        for (int j = 0; j < H; j++) begin
            if (k_q == KW'(j)) begin
                coef_sel = coef_q[j];
                if (j < H - 1) pre = (D_W+1)'(x_sel[j]) + (D_W+1)'(x_sel[TAPS-1-j]);
                else           pre = (D_W+1)'(x_sel[j]);
            end
        end

        accept  = in_valid && (state_q == IDLE) && (int'(in_ch) < CH);
        coef_we = coeff_wr && (state_q == IDLE) && !accept && (int'(coeff_addr) < H);

        state_d     = state_q;
        k_d         = k_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = prod_vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        dl_d        = dl_q;
        coef_d      = coef_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int c = 0; c < CH; c++) begin
                        if (in_ch == CW'(c)) begin
                            dl_d[c][0] = in_data;
                            for (int t = 1; t < TAPS; t++) dl_d[c][t] = dl_q[c][t-1];
                        end
                    end
                    ch_d       = in_ch;
                    acc_d      = '0;
                    k_d        = '0;
                    prod_vld_d = 1'b0;
                    state_d    = MAC;
                end else if (coef_we) begin
                    for (int j = 0; j < H; j++) if (coeff_addr == AW'(j)) coef_d[j] = coeff_data;
                end
            end
            // Product is registered; accumulation trails it by one cycle.
            MAC: begin
                if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);
                if (k_q == KW'(H)) begin
                    prod_vld_d = 1'b0;
                    state_d    = ROUND;
                end else begin
                    prod_d     = pre * coef_sel;
                    prod_vld_d = 1'b1;
                    k_d        = k_q + 1'b1;
                end
            end
            ROUND: begin
                out_data_d  = reduce_out(round_shift(acc_q));
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int c = 0; c < CH; c++)
                for (int t = 0; t < TAPS; t++) dl_q[c][t] <= '0;
            for (int j = 0; j < H; j++) coef_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            dl_q        <= dl_d;
            coef_q      <= coef_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_fir_sym_tdm.sv
`timescale 1ns/1ps
// Directed bench for fir_sym_tdm: TAPS=5, CH=2 instances for the base filter,
// for SHIFT=1 rounding and for OUT_W=16 saturation/wrap.
module tb_fir_sym_tdm;
    localparam int NI = 3;
`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [11:0] in_data    [NI];
    logic               in_ch      [NI];
    logic               in_valid   [NI];
    logic               in_ready   [NI];
    logic               out_ch     [NI];
    logic               out_valid  [NI];
    logic               out_ready  [NI];
    logic               coeff_wr   [NI];
    logic [1:0]         coeff_addr [NI];
    logic signed [17:0] coeff_data [NI];
    logic               busy       [NI];
    logic signed [23:0] od0, od1;
    logic signed [15:0] od2;
    logic signed [23:0] out_data   [NI];

    assign out_data[0] = od0;
    assign out_data[1] = od1;
    assign out_data[2] = 24'(od2);

    fir_sym_tdm #(.TAPS(5), .CH(2), .SHIFT(0), .OUT_W(24)) u0 (
        .clock(clk), .reset(rst), .in_data(in_data[0]), .in_ch(in_ch[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(od0), .out_ch(out_ch[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .coeff_wr(coeff_wr[0]),
        .coeff_addr(coeff_addr[0]), .coeff_data(coeff_data[0]), .busy(busy[0]));
    fir_sym_tdm #(.TAPS(5), .CH(2), .SHIFT(1), .OUT_W(24)) u1 (
        .clock(clk), .reset(rst), .in_data(in_data[1]), .in_ch(in_ch[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(od1), .out_ch(out_ch[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .coeff_wr(coeff_wr[1]),
        .coeff_addr(coeff_addr[1]), .coeff_data(coeff_data[1]), .busy(busy[1]));
    fir_sym_tdm #(.TAPS(5), .CH(2), .SHIFT(0), .OUT_W(16)) u2 (
        .clock(clk), .reset(rst), .in_data(in_data[2]), .in_ch(in_ch[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_data(od2), .out_ch(out_ch[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .coeff_wr(coeff_wr[2]),
        .coeff_addr(coeff_addr[2]), .coeff_data(coeff_data[2]), .busy(busy[2]));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int u;
        int ch;
        int d;
        int wr;
        int exp;
        int exp_ch;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int u, input int a, input int d);
        coeff_wr[u]   = 1'b1;
        coeff_addr[u] = 2'(a);
        coeff_data[u] = 18'(d);
        tick();
        coeff_wr[u] = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen; 0 on timeout.
    task automatic wait_out(input int u, input bit drop_wr, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (drop_wr && i == 3) coeff_wr[u] = 1'b0;
            if (out_valid[u]) begin
                lat = i;
                break;
            end
        end
    endtask

    // wr: 0 none, 1 coeff write on the accepting edge, 2 coeff write during MAC.
    task automatic send(input int u, input int ch, input int d, input int wr,
                        output longint y, output int ch_o, output int lat);
        int n;
        n = 0;
        while (!in_ready[u] && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready[u]) check("ready_timeout", 0, 1);
        in_ch[u]    = 1'(ch);
        in_data[u]  = 12'(d);
        in_valid[u] = 1'b1;
        if (wr != 0) begin
            coeff_addr[u] = 2'd0;
            coeff_data[u] = 18'sd99;
        end
        coeff_wr[u] = (wr == 1);
        tick();
        in_valid[u] = 1'b0;
        coeff_wr[u] = (wr == 2);
        wait_out(u, wr == 2, lat);
        y    = longint'(out_data[u]);
        ch_o = int'(out_ch[u]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint y;
        int     c, lat;
        string  nm;

        for (int u = 0; u < NI; u++) begin
            in_data[u] = '0; in_ch[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b1;
            coeff_wr[u] = 1'b0; coeff_addr[u] = '0; coeff_data[u] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int u = 0; u < NI; u++) begin
            check($sformatf("rst_out_valid_%0d", u), longint'(out_valid[u]), 0);
            check($sformatf("rst_in_ready_%0d", u), longint'(in_ready[u]), 1);
            check($sformatf("rst_busy_%0d", u), longint'(busy[u]), 0);
            check($sformatf("rst_out_data_%0d", u), longint'(out_data[u]), 0);
        end
        #2 rst = 1'b0;

        wr_coef(0, 0, 1);      wr_coef(0, 1, 2);      wr_coef(0, 2, 3);
        wr_coef(1, 0, 3);      wr_coef(1, 1, 0);      wr_coef(1, 2, 0);
        wr_coef(2, 0, 131071); wr_coef(2, 1, 131071); wr_coef(2, 2, 131071);
        wr_coef(0, 3, 77);

        // Impulse on ch0 with h = 1,2,3,2,1
        tbl.push_back('{0, 0, 100, 0, 100, 0});
        tbl.push_back('{0, 0, 0, 0, 200, 0});
        tbl.push_back('{0, 0, 0, 0, 300, 0});
        tbl.push_back('{0, 0, 0, 0, 200, 0});
        tbl.push_back('{0, 0, 0, 0, 100, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0});
        // Channel isolation: ch1 samples interleaved with a fresh ch0 impulse
        tbl.push_back('{0, 0, 100, 0, 100, 0});
        tbl.push_back('{0, 1, 7, 0, 7, 1});
        tbl.push_back('{0, 0, 0, 0, 200, 0});
        tbl.push_back('{0, 0, 0, 0, 300, 0});
        tbl.push_back('{0, 0, 0, 0, 200, 0});
        tbl.push_back('{0, 1, 0, 0, 14, 1});
        tbl.push_back('{0, 0, 0, 0, 100, 0});
        // ch1 history [7,0,...]; coeff writes during MAC / on accept must be dropped
        tbl.push_back('{0, 1, 1, 2, 22, 1});
        tbl.push_back('{0, 1, 0, 0, 16, 1});
        tbl.push_back('{0, 1, 2, 0, 12, 1});
        tbl.push_back('{0, 1, 0, 1, 6, 1});
        tbl.push_back('{0, 1, 3, 0, 10, 1});
        // SHIFT=1, h0=3: round half up
        tbl.push_back('{1, 0, 1, 0, 2, 0});
        tbl.push_back('{1, 0, -1, 0, -1, 0});
        tbl.push_back('{1, 0, 5, 0, 8, 0});
        tbl.push_back('{1, 0, -5, 0, -7, 0});
        // OUT_W=16, all h=131071, x=2047: 2047*131071 = -2047 mod 2^16 per tap
        for (int n = 1; n <= 5; n++)
            tbl.push_back('{2, 0, 2047, 0, SAT ? 32767 : -2047 * n, 0});

        foreach (tbl[i]) begin
            send(tbl[i].u, tbl[i].ch, tbl[i].d, tbl[i].wr, y, c, lat);
            nm = $sformatf("vec%0d_u%0d", i, tbl[i].u);
            check({nm, "_data"}, y, tbl[i].exp);
            check({nm, "_ch"}, c, tbl[i].exp_ch);
            check({nm, "_latency"}, lat, 5);
        end

        // Backpressure: output held for 10 cycles, next sample accepted right after handshake
        out_ready[0] = 1'b0;
        send(0, 0, 50, 0, y, c, lat);
        check("bp_data", y, 50);
        check("bp_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", longint'(out_data[0]), 50);
            check("bp_hold_valid", longint'(out_valid[0]), 1);
            check("bp_in_ready", longint'(in_ready[0]), 0);
        end
        in_ch[0] = 1'b0; in_data[0] = 12'sd0; in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        check("bp_valid_drop", longint'(out_valid[0]), 0);
        check("bp_ready_back", longint'(in_ready[0]), 1);
        tick();
        in_valid[0] = 1'b0;
        check("bp_accepted", longint'(busy[0]), 1);
        wait_out(0, 1'b0, lat);
        check("bp_next_latency", lat, 5);
        check("bp_next_data", longint'(out_data[0]), 100);

        // Reset in the middle of MAC, then impulse with cleared coefficients
        tick();
        in_ch[0] = 1'b0; in_data[0] = 12'sd9; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        check("mid_mac_busy", longint'(busy[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", longint'(out_valid[0]), 0);
        check("arst_in_ready", longint'(in_ready[0]), 1);
        check("arst_busy", longint'(busy[0]), 0);
        check("arst_out_data", longint'(out_data[0]), 0);
        #2 rst = 1'b0;
        send(0, 0, 100, 0, y, c, lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_y0", y, 0);
        send(0, 0, 0, 0, y, c, lat);
        check("post_rst_y1", y, 0);
        send(0, 0, 0, 0, y, c, lat);
        check("post_rst_y2", y, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
